// File: rtl/bcd_conv_ctrl.sv
// Sequencer for the serial BCD-to-binary converter: accepts a packed BCD word, clears the
// converter, feeds digits MSD-first, then holds the result. Optional macro: BCD_CTRL_DIGIT_CHECK_EN.
module bcd_conv_ctrl #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned OUT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  conv_clear,
    output logic                  conv_load,
    output logic [3:0]            conv_digit,
    input  logic [OUT_W-1:0]      conv_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      result,
    output logic                  err
);

    localparam int unsigned CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SHIFT_W = 4 * DIGITS;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StWait,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]     result_q, result_d;
    logic                 err_q, err_d;
    logic                 accept;
    logic                 last_digit;
    logic                 bad_digit;

    assign accept     = in_valid & in_ready;
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

`ifdef BCD_CTRL_DIGIT_CHECK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`else
    assign bad_digit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = bad_digit ? StDone : StClear;
                end
            end
            StClear: state_d = StFeed;
            StFeed: begin
                if (last_digit) begin
                    state_d = StWait;
                end
            end
            StWait: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d = bcd_in;
                    // A rejected word reports immediately with a zero result.
                    if (bad_digit) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            StClear: cnt_d = '0;
            StFeed: begin
                shift_d = shift_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            StWait: begin
                result_d = conv_result;
                err_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        // Held low while reset is asserted even though the state is already idle.
        in_ready   = (state_q == StIdle) && reset;
        conv_clear = (state_q == StClear);
        conv_load  = (state_q == StFeed);
        conv_digit = conv_load ? shift_q[SHIFT_W-1 -: 4] : 4'd0;
        out_valid  = (state_q == StDone);
        result     = result_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Directed bench for bcd_conv_ctrl with DIGITS=2, OUT_W=8 and a behavioural converter model.
module tb_bcd_conv_ctrl;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned OUT_W  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        bcd_in = 8'h00;
    logic              conv_clear;
    logic              conv_load;
    logic [3:0]        conv_digit;
    logic [OUT_W-1:0]  conv_result;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  result;
    logic              err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc[$];
    int res_q[$];
    logic [OUT_W-1:0] acc;

    always #5 clk = ~clk;

    bcd_conv_ctrl #(
        .DIGITS (DIGITS),
        .OUT_W  (OUT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bcd_in      (bcd_in),
        .conv_clear  (conv_clear),
        .conv_load   (conv_load),
        .conv_digit  (conv_digit),
        .conv_result (conv_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .err         (err)
    );

    // Converter model: acc <= acc*10 + digit on load, cleared on clear.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (conv_clear) begin
            acc <= '0;
        end else if (conv_load) begin
            acc <= OUT_W'(acc * 10 + conv_digit);
        end
    end
    assign conv_result = acc;

    always @(posedge clk) begin
        cyc++;
        if (reset && in_valid && in_ready) acc_cyc.push_back(cyc);
        if (out_valid && out_ready) res_q.push_back(int'(result));
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accepts one word and checks every cycle up to DONE.
    task automatic run_word(input logic [7:0] bcd, input int unsigned exp_res);
        logic [7:0] w;
        w = bcd;
        @(negedge clk);
        check_eq("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        bcd_in   = w;
        @(negedge clk);
        in_valid = 1'b0;
        bcd_in   = 8'hFF;
        check_eq("clear_pulse", conv_clear, 1);
        check_eq("clear_noload", conv_load, 0);
        check_eq("clear_busy", in_ready, 0);
        @(negedge clk);
        check_eq("feed0_load", conv_load, 1);
        check_eq("feed0_noclear", conv_clear, 0);
        check_eq("feed0_digit", conv_digit, w[7:4]);
        @(negedge clk);
        check_eq("feed1_load", conv_load, 1);
        check_eq("feed1_digit", conv_digit, w[3:0]);
        @(negedge clk);
        check_eq("wait_noload", conv_load, 0);
        check_eq("wait_digit", conv_digit, 0);
        check_eq("wait_novalid", out_valid, 0);
        @(negedge clk);
        check_eq("done_valid", out_valid, 1);
        check_eq("done_result", result, exp_res);
        check_eq("done_err", err, 0);
        check_eq("done_busy", in_ready, 0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("drain_valid", out_valid, 0);
        check_eq("drain_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("rst_ready", in_ready, 0);
        check_eq("rst_clear", conv_clear, 0);
        check_eq("rst_load", conv_load, 0);
        check_eq("rst_digit", conv_digit, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_word(8'h45, 45);
        drain();
        run_word(8'h99, 99);
        drain();
        run_word(8'h00, 0);
        drain();

        // Consumer stalls for 5 cycles; new requests must be ignored.
        run_word(8'h23, 23);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            bcd_in   = 8'h88;
            @(negedge clk);
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_result", result, 23);
            check_eq("stall_busy", in_ready, 0);
        end
        in_valid = 1'b0;
        drain();

        // Abort mid-FEED.
        @(negedge clk);
        in_valid = 1'b1;
        bcd_in   = 8'h45;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("abort_ready", in_ready, 0);
        check_eq("abort_clear", conv_clear, 0);
        check_eq("abort_load", conv_load, 0);
        check_eq("abort_digit", conv_digit, 0);
        check_eq("abort_valid", out_valid, 0);
        check_eq("abort_result", result, 0);
        check_eq("abort_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        run_word(8'h17, 17);
        drain();

`ifdef BCD_CTRL_DIGIT_CHECK_EN
        @(negedge clk);
        in_valid = 1'b1;
        bcd_in   = 8'h3A;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("bad_valid", out_valid, 1);
        check_eq("bad_err", err, 1);
        check_eq("bad_result", result, 0);
        check_eq("bad_clear", conv_clear, 0);
        check_eq("bad_load", conv_load, 0);
        drain();
`else
        // Raw feed: 3*10 + 10 from the model, no error flag.
        run_word(8'h3A, 40);
        drain();
`endif

        // Back-to-back with in_valid and out_ready held.
        acc_cyc.delete();
        res_q.delete();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 8'h12;
        for (int i = 0; i < 20 && acc_cyc.size() < 1; i++) @(negedge clk);
        bcd_in = 8'h34;
        for (int i = 0; i < 20 && acc_cyc.size() < 2; i++) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && res_q.size() < 2; i++) @(negedge clk);
        check_eq("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check_eq("b2b_spacing", acc_cyc[1] - acc_cyc[0], DIGITS + 4);
        check_eq("b2b_results", res_q.size(), 2);
        if (res_q.size() == 2) begin
            check_eq("b2b_res0", res_q[0], 12);
            check_eq("b2b_res1", res_q[1], 34);
        end
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
